// File: rtl/multicycle_control.sv
// Multicycle LEGv8-style control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// a bounded memory wait, sticky illegal/fault flags and a retired-instruction counter.
module multicycle_control #(
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [10:0] opcode,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        pc_write,
    output logic        Branch,
    output logic        Uncondbranch,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic [1:0]  ALUOp,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        fault,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_R   = 3'd0,
        CL_LD  = 3'd1,
        CL_ST  = 3'd2,
        CL_CBZ = 3'd3,
        CL_B   = 3'd4
    } class_t;

    // Index of the last wait cycle that may still see mem_ready before faulting.
    localparam logic [15:0] WAIT_LAST = 16'(MEM_WAIT_MAX - 1);

    state_t      state_q;
    class_t      cls;
    class_t      dec_class;
    logic        dec_legal;
    logic [15:0] wait_cnt;

    assign state = state_q;

    always_comb begin
        dec_legal = 1'b1;
        dec_class = CL_R;
        if (opcode == 11'b10001011000 || opcode == 11'b11001011000 ||
            opcode == 11'b10001010000 || opcode == 11'b10101010000) begin
            dec_class = CL_R;
        end else if (opcode == 11'b11111000010) begin
            dec_class = CL_LD;
        end else if (opcode == 11'b11111000000) begin
            dec_class = CL_ST;
        end else if (opcode[10:3] == 8'b10110100) begin
            dec_class = CL_CBZ;
        end else if (opcode[10:5] == 6'b000101) begin
            dec_class = CL_B;
        end else begin
            dec_legal = 1'b0;
        end
    end

    // Strobes decode from the registered state; a reset cycle drives nothing so
    // an in-flight store cannot pulse pc_write while being aborted.
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        pc_write     = 1'b0;
        Branch       = 1'b0;
        Uncondbranch = 1'b0;
        Reg2Loc      = 1'b0;
        ALUSrc       = 1'b0;
        MemtoReg     = 1'b0;
        ALUOp        = 2'b00;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    if (run) begin
                        mem_read = 1'b1;
                        ir_write = mem_ready;
                    end
                end
                EXEC: begin
                    case (cls)
                        CL_R:   ALUOp = 2'b10;
                        CL_LD:  ALUSrc = 1'b1;
                        CL_ST: begin
                            ALUSrc  = 1'b1;
                            Reg2Loc = 1'b1;
                        end
                        CL_CBZ: begin
                            ALUOp    = 2'b01;
                            Reg2Loc  = 1'b1;
                            pc_write = 1'b1;
                            Branch   = 1'b1;
                        end
                        CL_B: begin
                            pc_write     = 1'b1;
                            Uncondbranch = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    if (cls == CL_LD) begin
                        mem_read = 1'b1;
                    end else if (cls == CL_ST) begin
                        mem_write = 1'b1;
                        pc_write  = mem_ready;
                    end
                end
                WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    MemtoReg  = (cls == CL_LD);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= FETCH;
            cls      <= CL_R;
            illegal  <= 1'b0;
            fault    <= 1'b0;
            retired  <= 32'd0;
            wait_cnt <= 16'd0;
        end else begin
            if (pc_write) begin
                retired <= retired + 32'd1;
            end
            case (state_q)
                FETCH: begin
                    if (!run) begin
                        wait_cnt <= 16'd0;
                    end else if (mem_ready) begin
                        wait_cnt <= 16'd0;
                        state_q  <= DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= 16'd0;
                        fault    <= 1'b1;
                        state_q  <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DECODE: begin
                    if (dec_legal) begin
                        cls     <= dec_class;
                        state_q <= EXEC;
                    end else begin
                        illegal <= 1'b1;
                        state_q <= HALT;
                    end
                end
                EXEC: begin
                    if (cls == CL_R) begin
                        state_q <= WB;
                    end else if (cls == CL_LD || cls == CL_ST) begin
                        state_q <= MEM;
                    end else begin
                        state_q <= FETCH;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        wait_cnt <= 16'd0;
                        if (cls == CL_LD) begin
                            state_q <= WB;
                        end else begin
                            state_q <= FETCH;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= 16'd0;
                        fault    <= 1'b1;
                        state_q  <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                WB:      state_q <= FETCH;
                HALT:    state_q <= HALT;
                default: state_q <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each driven cycle pushes its expected
// state/strobe/flag/count snapshot; a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam int W = 49;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_LD  = 11'b11111000010;
    localparam logic [10:0] OP_ST  = 11'b11111000000;
    localparam logic [10:0] OP_CBZ = 11'b10110100101;
    localparam logic [10:0] OP_B   = 11'b00010100000;
    localparam logic [10:0] OP_BAD = 11'b00000000000;

    // strobe order: mem_read mem_write ir_write reg_write pc_write Branch Uncondbranch Reg2Loc ALUSrc MemtoReg
    localparam logic [9:0] S_NONE  = 10'b0000000000;
    localparam logic [9:0] S_FRD   = 10'b1000000000;
    localparam logic [9:0] S_FIR   = 10'b1010000000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [10:0] opcode = 11'd0;
    logic        mem_ready = 1'b0;
    logic        mem_read, mem_write, ir_write, reg_write, pc_write;
    logic        Branch, Uncondbranch, Reg2Loc, ALUSrc, MemtoReg;
    logic [1:0]  ALUOp;
    logic [2:0]  state;
    logic        illegal, fault;
    logic [31:0] retired;
    logic [9:0]  strb;

    multicycle_control #(.MEM_WAIT_MAX(4)) dut (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .pc_write(pc_write), .Branch(Branch),
        .Uncondbranch(Uncondbranch), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc),
        .MemtoReg(MemtoReg), .ALUOp(ALUOp), .state(state), .illegal(illegal),
        .fault(fault), .retired(retired)
    );

    always #5 clock = ~clock;

    assign strb = {mem_read, mem_write, ir_write, reg_write, pc_write,
                   Branch, Uncondbranch, Reg2Loc, ALUSrc, MemtoReg};

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] mon_exp, mon_act;
    string        mon_tag;

    // One cycle of stimulus plus the snapshot expected during that cycle.
    task automatic step(input logic rst, input logic rn, input logic [10:0] op,
                        input logic rdy, input logic [2:0] st, input logic [9:0] sb,
                        input logic [1:0] aop, input logic ill, input logic flt,
                        input logic [31:0] ret, input string tag);
        @(posedge clock);
        #1;
        reset     = rst;
        run       = rn;
        opcode    = op;
        mem_ready = rdy;
        exp_q.push_back({st, sb, aop, ill, flt, ret});
        tag_q.push_back(tag);
    endtask

    task automatic idle(input logic [31:0] ret, input string tag);
        step(1'b0, 1'b0, 11'd0, 1'b0, 3'd0, S_NONE, 2'b00, 1'b0, 1'b0, ret, tag);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_act = {state, strb, ALUOp, illegal, fault, retired};
            n_cmp++;
            if (mon_act !== mon_exp) begin
                n_bad++;
                $display("FAIL %s: got st=%0d strb=%b aluop=%b ill=%b flt=%b ret=%0d, want st=%0d strb=%b aluop=%b ill=%b flt=%b ret=%0d",
                         mon_tag, mon_act[48:46], mon_act[45:36], mon_act[35:34], mon_act[33],
                         mon_act[32], mon_act[31:0], mon_exp[48:46], mon_exp[45:36],
                         mon_exp[35:34], mon_exp[33], mon_exp[32], mon_exp[31:0]);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clock);
        idle(0, "reset");
        idle(0, "fetch_idle");

        // R-type ADD with immediate memory
        step(0, 1, OP_ADD, 1, 3'd0, S_FIR,         2'b00, 0, 0, 0, "add_fetch");
        step(0, 1, OP_ADD, 1, 3'd1, S_NONE,        2'b00, 0, 0, 0, "add_decode");
        step(0, 1, OP_ADD, 1, 3'd2, S_NONE,        2'b10, 0, 0, 0, "add_exec");
        step(0, 1, OP_ADD, 1, 3'd4, 10'b0001100000, 2'b00, 0, 0, 0, "add_wb");
        idle(1, "add_done");

        // Load with three MEM wait cycles; ready arrives on the last legal wait cycle
        step(0, 1, OP_LD, 1, 3'd0, S_FIR,          2'b00, 0, 0, 1, "ld_fetch");
        step(0, 1, OP_LD, 0, 3'd1, S_NONE,         2'b00, 0, 0, 1, "ld_decode");
        step(0, 1, OP_LD, 0, 3'd2, 10'b0000000010, 2'b00, 0, 0, 1, "ld_exec");
        step(0, 1, OP_LD, 0, 3'd3, S_FRD,          2'b00, 0, 0, 1, "ld_mem_w1");
        step(0, 1, OP_LD, 0, 3'd3, S_FRD,          2'b00, 0, 0, 1, "ld_mem_w2");
        step(0, 1, OP_LD, 0, 3'd3, S_FRD,          2'b00, 0, 0, 1, "ld_mem_w3");
        step(0, 1, OP_LD, 1, 3'd3, S_FRD,          2'b00, 0, 0, 1, "ld_mem_rdy");
        step(0, 1, OP_LD, 0, 3'd4, 10'b0001100001, 2'b00, 0, 0, 1, "ld_wb");
        idle(2, "ld_done");

        // Store, no wait
        step(0, 1, OP_ST, 1, 3'd0, S_FIR,          2'b00, 0, 0, 2, "st_fetch");
        step(0, 1, OP_ST, 1, 3'd1, S_NONE,         2'b00, 0, 0, 2, "st_decode");
        step(0, 1, OP_ST, 0, 3'd2, 10'b0000000110, 2'b00, 0, 0, 2, "st_exec");
        step(0, 1, OP_ST, 1, 3'd3, 10'b0100100000, 2'b00, 0, 0, 2, "st_mem");
        idle(3, "st_done");

        // CBZ and B
        step(0, 1, OP_CBZ, 1, 3'd0, S_FIR,          2'b00, 0, 0, 3, "cbz_fetch");
        step(0, 1, OP_CBZ, 1, 3'd1, S_NONE,         2'b00, 0, 0, 3, "cbz_decode");
        step(0, 1, OP_CBZ, 1, 3'd2, 10'b0000110100, 2'b01, 0, 0, 3, "cbz_exec");
        idle(4, "cbz_done");
        step(0, 1, OP_B, 1, 3'd0, S_FIR,          2'b00, 0, 0, 4, "b_fetch");
        step(0, 1, OP_B, 1, 3'd1, S_NONE,         2'b00, 0, 0, 4, "b_decode");
        step(0, 1, OP_B, 1, 3'd2, 10'b0000101000, 2'b00, 0, 0, 4, "b_exec");
        idle(5, "b_done");

        // ORR with two FETCH wait cycles
        step(0, 1, OP_ORR, 0, 3'd0, S_FRD,          2'b00, 0, 0, 5, "orr_fetch_w1");
        step(0, 1, OP_ORR, 0, 3'd0, S_FRD,          2'b00, 0, 0, 5, "orr_fetch_w2");
        step(0, 1, OP_ORR, 1, 3'd0, S_FIR,          2'b00, 0, 0, 5, "orr_fetch");
        step(0, 1, OP_ORR, 0, 3'd1, S_NONE,         2'b00, 0, 0, 5, "orr_decode");
        step(0, 1, OP_ORR, 0, 3'd2, S_NONE,         2'b10, 0, 0, 5, "orr_exec");
        step(0, 1, OP_ORR, 0, 3'd4, 10'b0001100000, 2'b00, 0, 0, 5, "orr_wb");
        idle(6, "orr_done");

        // Reset while a store waits in MEM, with mem_ready high in the reset cycle
        step(0, 1, OP_ST, 1, 3'd0, S_FIR,          2'b00, 0, 0, 6, "rst_st_fetch");
        step(0, 1, OP_ST, 0, 3'd1, S_NONE,         2'b00, 0, 0, 6, "rst_st_decode");
        step(0, 1, OP_ST, 0, 3'd2, 10'b0000000110, 2'b00, 0, 0, 6, "rst_st_exec");
        step(0, 1, OP_ST, 0, 3'd3, 10'b0100000000, 2'b00, 0, 0, 6, "rst_st_mem_w1");
        step(0, 1, OP_ST, 0, 3'd3, 10'b0100000000, 2'b00, 0, 0, 6, "rst_st_mem_w2");
        step(1, 1, OP_ST, 1, 3'd3, S_NONE,         2'b00, 0, 0, 6, "rst_st_assert");
        idle(0, "rst_st_after");

        // FETCH timeout with MEM_WAIT_MAX=4
        for (int i = 0; i < 4; i++) begin
            step(0, 1, OP_ADD, 0, 3'd0, S_FRD, 2'b00, 0, 0, 0, "to_fetch_wait");
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, OP_ADD, 1, 3'd5, S_NONE, 2'b00, 0, 1, 0, "to_halt");
        end
        step(1, 1, OP_ADD, 1, 3'd5, S_NONE, 2'b00, 0, 1, 0, "to_reset_cycle");
        idle(0, "to_after_reset");

        // Illegal opcode
        step(0, 1, OP_BAD, 1, 3'd0, S_FIR,  2'b00, 0, 0, 0, "ill_fetch");
        step(0, 1, OP_BAD, 1, 3'd1, S_NONE, 2'b00, 0, 0, 0, "ill_decode");
        for (int i = 0; i < 20; i++) begin
            step(0, 1, OP_ADD, 1, 3'd5, S_NONE, 2'b00, 1, 0, 0, "ill_halt");
        end
        step(1, 0, 11'd0, 0, 3'd5, S_NONE, 2'b00, 1, 0, 0, "ill_reset_cycle");
        idle(0, "ill_after_reset");

        repeat (3) @(posedge clock);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
